// File: rtl/mul_pkg.sv
// Shared widths and HI/LO slicing for the multiply result path.
package mul_pkg;

   localparam int PROD_W = 64;
   localparam int WORD_W = 32;
   localparam int HI_MSB = 63;
   localparam int HI_LSB = 32;
   localparam int LO_MSB = 31;
   localparam int LO_LSB = 0;

   typedef struct packed {
      logic [WORD_W-1:0] hi;
      logic [WORD_W-1:0] lo;
   } hilo_t;

   function automatic hilo_t split_prod(input logic [PROD_W-1:0] p);
      hilo_t r;
      r.hi = p[HI_MSB:HI_LSB];
      r.lo = p[LO_MSB:LO_LSB];
      return r;
   endfunction

endpackage

// File: rtl/mul_prod_fifo.sv
// Product buffer between the Booth multiplier and the HI/LO registers.
module mul_prod_fifo
   import mul_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [PROD_W-1:0]        din,
   output logic [PROD_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PROD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Pointers wrap by natural overflow since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/mul_hilo_stage.sv
// HI/LO register stage: buffers multiplier products and commits them on request.
module mul_hilo_stage
   import mul_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PROD_W-1:0]        in_product,
   input  logic                     commit_en,
   input  logic                     hi_wr,
   input  logic                     lo_wr,
   input  logic [WORD_W-1:0]        bus_in,
   output logic [WORD_W-1:0]        hi_q,
   output logic [WORD_W-1:0]        lo_q,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     hilo_valid
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WORD_W-1:0] hi_reg_q, hi_reg_d;
   logic [WORD_W-1:0] lo_reg_q, lo_reg_d;
   logic              valid_q, valid_d;
   logic [PROD_W-1:0] head;
   logic              push, pop;
   hilo_t             head_split;

   assign in_ready   = (pending != FULL_CNT);
   assign push       = in_valid && in_ready;
   assign pop        = commit_en && (pending != '0) && !hi_wr && !lo_wr;
   assign head_split = split_prod(head);

   mul_prod_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .din   (in_product),
      .dout  (head),
      .count (pending)
   );

   // Direct writes win over a commit; the stalled commit leaves the FIFO intact.
   always_comb begin
      hi_reg_d = hi_reg_q;
      lo_reg_d = lo_reg_q;
      valid_d  = valid_q;
      if (hi_wr || lo_wr) begin
         if (hi_wr) hi_reg_d = bus_in;
         if (lo_wr) lo_reg_d = bus_in;
         valid_d = 1'b0;
      end else if (pop) begin
         hi_reg_d = head_split.hi;
         lo_reg_d = head_split.lo;
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         hi_reg_q <= '0;
         lo_reg_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         hi_reg_q <= hi_reg_d;
         lo_reg_q <= lo_reg_d;
         valid_q  <= valid_d;
      end
   end

   assign hi_q       = hi_reg_q;
   assign lo_q       = lo_reg_q;
   assign hilo_valid = valid_q;

endmodule

// File: tb/tb_mul_hilo_stage.sv
// Scoreboard bench for mul_hilo_stage against a queue-based behavioural model.
module tb_mul_hilo_stage;

   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          clr;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_product;
   logic          commit_en;
   logic          hi_wr;
   logic          lo_wr;
   logic [31:0]   bus_in;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic [CW-1:0] pending;
   logic          hilo_valid;

   always #5 clk = ~clk;

   mul_hilo_stage #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .clr        (clr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .commit_en  (commit_en),
      .hi_wr      (hi_wr),
      .lo_wr      (lo_wr),
      .bus_in     (bus_in),
      .hi_q       (hi_q),
      .lo_q       (lo_q),
      .pending    (pending),
      .hilo_valid (hilo_valid)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      bit          valid;
      int          pend;
      bit          ready;
   } exp_t;

   exp_t        expq[$];
   logic [63:0] m_fifo[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   bit          m_valid = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;

   // Apply one cycle of inputs, advance the model with the same inputs.
   task automatic step(input bit c, input bit iv, input logic [63:0] p,
                       input bit ce, input bit hw, input bit lw,
                       input logic [31:0] b);
      bit ready, commit;
      exp_t e;
      clr = c; in_valid = iv; in_product = p;
      commit_en = ce; hi_wr = hw; lo_wr = lw; bus_in = b;
      @(posedge clk);
      ready  = (m_fifo.size() != DEPTH);
      commit = ce && (m_fifo.size() != 0) && !hw && !lw;
      if (c) begin
         m_fifo.delete();
         m_hi = '0; m_lo = '0; m_valid = 1'b0;
      end else begin
         if (hw) m_hi = b;
         if (lw) m_lo = b;
         if (hw || lw) m_valid = 1'b0;
         else if (commit) begin
            logic [63:0] h;
            h = m_fifo.pop_front();
            m_hi = h[63:32];
            m_lo = h[31:0];
            m_valid = 1'b1;
         end
         if (iv && ready) m_fifo.push_back(p);
      end
      e.hi = m_hi; e.lo = m_lo; e.valid = m_valid;
      e.pend = m_fifo.size(); e.ready = (m_fifo.size() != DEPTH);
      expq.push_back(e);
      #1;
   endtask

   task automatic idle();
      step(0, 0, '0, 0, 0, 0, '0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            vectors++;
            if (hi_q !== e.hi) begin
               miscompares++;
               $display("FAIL hi_q t=%0t got %h want %h", $time, hi_q, e.hi);
            end
            if (lo_q !== e.lo) begin
               miscompares++;
               $display("FAIL lo_q t=%0t got %h want %h", $time, lo_q, e.lo);
            end
            if (hilo_valid !== e.valid) begin
               miscompares++;
               $display("FAIL hilo_valid t=%0t got %b want %b", $time, hilo_valid, e.valid);
            end
            if (pending !== CW'(e.pend)) begin
               miscompares++;
               $display("FAIL pending t=%0t got %0d want %0d", $time, pending, e.pend);
            end
            if (in_ready !== e.ready) begin
               miscompares++;
               $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, e.ready);
            end
         end
      end
   end

   initial begin : driver
      logic [63:0] neg15;
      int guard;
      neg15 = 64'hFFFF_FFFF_FFFF_FFF1;
      clr = 1'b1; in_valid = 0; in_product = '0; commit_en = 0;
      hi_wr = 0; lo_wr = 0; bus_in = '0;
      #1;
      step(1, 0, '0, 0, 0, 0, '0);
      step(1, 1, 64'h1234, 1, 1, 1, 32'hDEAD_BEEF);

      // -3*5 pushed, committed next cycle
      step(0, 1, neg15, 0, 0, 0, '0);
      step(0, 0, '0, 1, 0, 0, '0);
      idle();

      // fill past DEPTH without committing
      step(0, 1, 64'h1111_1111_2222_2222, 0, 0, 0, '0);
      step(0, 1, 64'h3333_3333_4444_4444, 0, 0, 0, '0);
      step(0, 1, 64'h5555_5555_6666_6666, 0, 0, 0, '0);
      step(0, 0, '0, 1, 0, 0, '0);
      // pending=1: push and commit together
      step(0, 1, 64'h7777_7777_8888_8888, 1, 0, 0, '0);
      step(0, 0, '0, 1, 0, 0, '0);
      // pending=1: commit stalled by MTHI
      step(0, 1, 64'h9999_9999_AAAA_AAAA, 0, 0, 0, '0);
      step(0, 0, '0, 1, 1, 0, 32'h1234_5678);
      step(0, 0, '0, 1, 0, 1, 32'h0BAD_F00D);
      step(0, 0, '0, 1, 1, 1, 32'hCAFE_0001);
      step(0, 0, '0, 1, 0, 0, '0);
      // commit with an empty buffer
      step(0, 0, '0, 1, 0, 0, '0);
      idle();
      // full buffer, clr together with commit
      step(0, 1, 64'hABCD_0000_0000_ABCD, 0, 0, 0, '0);
      step(0, 1, 64'h0000_1234_5678_0000, 0, 0, 0, '0);
      step(1, 1, 64'hFFFF_0000_FFFF_0000, 1, 0, 0, '0);
      idle();

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0),
              ($urandom_range(0, 2) != 0),
              {$urandom, $urandom},
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) == 0),
              $urandom);
      end
      idle();

      guard = 0;
      while (expq.size() != 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d pending entries want 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
